// File: rtl/hp_sample_queue.sv
// hp_sample_queue: dual-channel (L/R) circular sample store that replays the newest RD_LEN pairs oldest-first to the high-pass FIR.
// Latency: a write sampled at edge T is followed by RD_LEN window words sampled by the FIR at edges T+2 .. T+RD_LEN+1.
// Backpressure: none; writes are always accepted, and writes during a window coalesce into one extra window (sticky `overrun` port only when HPQ_OVERRUN_EN is defined).
module hp_sample_queue #(
   parameter int DEPTH  = 1536,
   parameter int RD_LEN = 1021,
   parameter int WIDTH  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wrt_smpl,
   input  logic [WIDTH-1:0] lft_smpl,
   input  logic [WIDTH-1:0] rght_smpl,
   output logic             sequencing,
   output logic [WIDTH-1:0] lft_out,
   output logic [WIDTH-1:0] rght_out
`ifdef HPQ_OVERRUN_EN
   ,
   output logic             overrun
`endif
);

   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int CW1 = CW + 1;
   localparam int IW  = $clog2(RD_LEN + 1);

   localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0]  RD_LEN_A  = AW'(RD_LEN);
   localparam logic [AW-1:0]  WRAP_OFS  = AW'(DEPTH - RD_LEN);
   localparam logic [CW-1:0]  CNT_MAX   = CW'(DEPTH);
   localparam logic [CW1-1:0] RD_LEN_C  = CW1'(RD_LEN);
   localparam logic [IW-1:0]  LAST_IDX  = IW'(RD_LEN - 1);

   typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, GAP} state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] mem_l [DEPTH];
   logic [WIDTH-1:0] mem_r [DEPTH];

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_addr;
   logic [AW-1:0]    start_addr;
   logic [AW-1:0]    rd_sel;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    rd_idx;
   logic             pending;
   logic             fill_ok;
   logic             first_rd;
   logic             rd_en;
   logic [WIDTH-1:0] rd_dat_l;
   logic [WIDTH-1:0] rd_dat_r;

   // Address increment with explicit wrap so DEPTH need not be a power of two
   function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + AW'(1);
   endfunction

   // Oldest window entry: newest sample sits at wr_ptr-1, so the window starts RD_LEN back from wr_ptr
   always_comb begin
      if (wr_ptr >= RD_LEN_A) start_addr = wr_ptr - RD_LEN_A;
      else                    start_addr = wr_ptr + WRAP_OFS;
   end

   // Enough history once this write brings the stored count up to RD_LEN
   assign fill_ok = ({1'b0, cnt} + CW1'(1)) >= RD_LEN_C;

   // GAP doubles as the address-load cycle so the forced-low interval between chained windows is one clk
   assign first_rd = (state == LOAD) || (state == GAP);
   assign rd_en    = first_rd || (state == READ);
   assign rd_sel   = first_rd ? start_addr : rd_addr;

   // Window data is valid while the registered read port holds READ/DRAIN words
   assign sequencing = (state == READ) || (state == DRAIN);
   assign lft_out    = sequencing ? rd_dat_l : '0;
   assign rght_out   = sequencing ? rd_dat_r : '0;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: a write at the DRAIN exit with nothing owed goes straight to LOAD
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (wrt_smpl && fill_ok) state_nxt = LOAD;
         LOAD, GAP: state_nxt = (RD_LEN == 1) ? DRAIN : READ;
         READ:      if (rd_idx == LAST_IDX) state_nxt = DRAIN;
         DRAIN: begin
            if (pending)       state_nxt = GAP;
            else if (wrt_smpl) state_nxt = LOAD;
            else               state_nxt = IDLE;
         end
         default:   state_nxt = IDLE;
      endcase
   end

   // Write pointer, saturating fill count, owed-window flag and read sequencing counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         cnt     <= '0;
         pending <= 1'b0;
         rd_addr <= '0;
         rd_idx  <= '0;
      end else begin
         if (wrt_smpl) begin
            wr_ptr <= addr_inc(wr_ptr);
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
         end
         if (state == GAP)
            pending <= wrt_smpl;
         else if (wrt_smpl && ((state == LOAD) || (state == READ)))
            pending <= 1'b1;
         if (first_rd) begin
            rd_addr <= addr_inc(start_addr);
            rd_idx  <= IW'(1);
         end else if (state == READ) begin
            rd_addr <= addr_inc(rd_addr);
            rd_idx  <= rd_idx + IW'(1);
         end
      end
   end

   // Sample storage and registered read port; contents are intentionally left unreset
   always_ff @(posedge clk) begin
      if (wrt_smpl) begin
         mem_l[wr_ptr] <= lft_smpl;
         mem_r[wr_ptr] <= rght_smpl;
      end
      if (rd_en) begin
         rd_dat_l <= mem_l[rd_sel];
         rd_dat_r <= mem_r[rd_sel];
      end
   end

`ifdef HPQ_OVERRUN_EN
   // Sticky flag: a write arrived while an extra window was already owed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   overrun <= 1'b0;
      else if (wrt_smpl && pending) overrun <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_hp_sample_queue.sv
// tb_hp_sample_queue: randomized and directed stimulus for hp_sample_queue against a sample-history reference model.
// The model keeps every written pair and predicts window timing from write edges only.
// Outputs are compared at every negedge; an optional overrun check follows HPQ_OVERRUN_EN.
module tb_hp_sample_queue;

   localparam int DEPTH  = 1536;
   localparam int RD_LEN = 1021;
   localparam int WIDTH  = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             wrt_smpl = 1'b0;
   logic [WIDTH-1:0] lft_smpl = '0;
   logic [WIDTH-1:0] rght_smpl = '0;
   logic             sequencing;
   logic [WIDTH-1:0] lft_out;
   logic [WIDTH-1:0] rght_out;
`ifdef HPQ_OVERRUN_EN
   logic             overrun;
`endif

   hp_sample_queue #(.DEPTH(DEPTH), .RD_LEN(RD_LEN), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrt_smpl   (wrt_smpl),
      .lft_smpl   (lft_smpl),
      .rght_smpl  (rght_smpl),
      .sequencing (sequencing),
      .lft_out    (lft_out),
      .rght_out   (rght_out)
`ifdef HPQ_OVERRUN_EN
      ,
      .overrun    (overrun)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: full write history plus the edge numbers of the current window
   logic [WIDTH-1:0] hl[$];
   logic [WIDTH-1:0] hr[$];
   int  e_cnt;      // posedges since reset release
   bit  win_on;     // a window is scheduled or running
   int  s_edge;     // first edge at which the FIR samples window word 0
   int  base;       // history index of window word 0
   bit  pend_any;   // a write landed while this window was busy
   bit  from_pend;  // this window was owed by an earlier coalesced write
   bit  exp_ovr;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", tag, act, exp, e_cnt);
      end
   endtask

   task automatic model_reset();
      hl.delete();
      hr.delete();
      e_cnt     = 0;
      win_on    = 1'b0;
      s_edge    = 0;
      base      = 0;
      pend_any  = 1'b0;
      from_pend = 1'b0;
      exp_ovr   = 1'b0;
   endtask

   // Window busy span: writes at edges s_edge-1 .. s_edge+RD_LEN-2 are owed a window;
   // edge s_edge+RD_LEN-1 decides whether another window follows at s_edge+RD_LEN+1.
   task automatic model_edge(input bit w, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
      e_cnt++;
      if (w) begin
         hl.push_back(l);
         hr.push_back(r);
      end
      if (win_on && (e_cnt < s_edge + RD_LEN - 1)) begin
         if (w) begin
            if (pend_any || (from_pend && (e_cnt == s_edge - 1))) exp_ovr = 1'b1;
            pend_any = 1'b1;
         end
      end else if (win_on) begin
         if (w && pend_any) exp_ovr = 1'b1;
         if (w || pend_any) begin
            from_pend = pend_any;
            pend_any  = 1'b0;
            s_edge    = e_cnt + 2;
            base      = hl.size() - RD_LEN;
         end else begin
            win_on = 1'b0;
         end
      end else if (w && (hl.size() >= RD_LEN)) begin
         win_on    = 1'b1;
         from_pend = 1'b0;
         pend_any  = 1'b0;
         s_edge    = e_cnt + 2;
         base      = hl.size() - RD_LEN;
      end
   endtask

   task automatic check_outputs();
      bit               vis;
      logic [WIDTH-1:0] el;
      logic [WIDTH-1:0] er;
      vis = win_on && (e_cnt >= s_edge - 1) && (e_cnt <= s_edge + RD_LEN - 2);
      el  = '0;
      er  = '0;
      if (vis) begin
         el = hl[base + e_cnt - s_edge + 1];
         er = hr[base + e_cnt - s_edge + 1];
      end
      chk("sequencing", 32'(sequencing), 32'(vis));
      chk("lft_out", 32'(lft_out), 32'(el));
      chk("rght_out", 32'(rght_out), 32'(er));
`ifdef HPQ_OVERRUN_EN
      chk("overrun", 32'(overrun), 32'(exp_ovr));
`endif
   endtask

   // One clock: drive at the negedge, model the posedge, check at the next negedge
   task automatic cyc(input bit w, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
      wrt_smpl  = w;
      lft_smpl  = l;
      rght_smpl = r;
      @(posedge clk);
      model_edge(w, l, r);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, '0, '0);
   endtask

   task automatic drain_all();
      for (int k = 0; (k < 4 * (RD_LEN + 4)) && win_on; k++) cyc(1'b0, '0, '0);
      idle(3);
   endtask

   // Idle until the next posedge will be edge number tgt
   task automatic run_to(input int tgt);
      for (int k = 0; (k < 4 * (RD_LEN + 4)) && (e_cnt + 1 < tgt); k++) cyc(1'b0, '0, '0);
   endtask

   // Asynchronous reset from between clock edges; outputs must clear without a clock
   task automatic do_reset();
      #2;
      wrt_smpl = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("rst_sequencing", 32'(sequencing), 32'd0);
      chk("rst_lft_out", 32'(lft_out), 32'd0);
      chk("rst_rght_out", 32'(rght_out), 32'd0);
`ifdef HPQ_OVERRUN_EN
      chk("rst_overrun", 32'(overrun), 32'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int gap;
      model_reset();
      #12;
      chk("por_sequencing", 32'(sequencing), 32'd0);
      chk("por_lft_out", 32'(lft_out), 32'd0);
      chk("por_rght_out", 32'(rght_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill: 1020 writes stay silent, the 1021st opens the first window (0..1020)
      for (int i = 0; i < RD_LEN; i++) cyc(1'b1, 16'(i), 16'(-i));
      drain_all();

      // Reset in the middle of a window, then a short refill that must not raise sequencing
      cyc(1'b1, 16'h1234, 16'h5678);
      idle(300);
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1'b1, 16'(i + 100), 16'(i + 200));
      idle(10);

      // Wrap: 1600 back-to-back writes; final window spans the wr_ptr wrap (579..1599)
      do_reset();
      for (int i = 0; i < 1600; i++) cyc(1'b1, 16'(i), 16'hFFFF - 16'(i));
      drain_all();

      // Mid-window write at window cycle 500, then a second window 1..1021
      do_reset();
      for (int i = 0; i < RD_LEN; i++) cyc(1'b1, 16'(i), 16'(-i));
      run_to(s_edge - 1 + 500);
      cyc(1'b1, 16'(RD_LEN), 16'(-RD_LEN));
      drain_all();

      // Coalesce: two writes inside one window yield a single extra window
      cyc(1'b1, 16'h0A00, 16'h0B00);
      run_to(s_edge - 1 + 100);
      cyc(1'b1, 16'h0A01, 16'h0B01);
      run_to(s_edge - 1 + 700);
      cyc(1'b1, 16'h0A02, 16'h0B02);
      drain_all();

      // Back-to-back: write exactly on the DRAIN exit edge, twice in a row
      cyc(1'b1, 16'h0C00, 16'h0D00);
      run_to(s_edge + RD_LEN - 1);
      cyc(1'b1, 16'h0C01, 16'h0D01);
      run_to(s_edge + RD_LEN - 1);
      cyc(1'b1, 16'h0C02, 16'h0D02);
      drain_all();

      // Randomized: random fill, then bursts and sparse writes landing anywhere in windows
      do_reset();
      for (int i = 0; i < RD_LEN; i++) begin
         if ($urandom_range(0, 7) == 0) cyc(1'b0, '0, '0);
         cyc(1'b1, 16'($urandom), 16'($urandom));
      end
      while (e_cnt < 40000) begin
         gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(20, 1400);
         repeat (gap - 1) cyc(1'b0, '0, '0);
         cyc(1'b1, 16'($urandom), 16'($urandom));
      end
      drain_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", e_cnt);
      $fatal(1, "watchdog");
   end

endmodule
